// File: rtl/reg_bus_pkg.sv
// Shared types for the register bus master: FSM states,
// default widths and the queued command layout.
package reg_bus_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 2;

`ifdef REG_BUS_MASTER_RBV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_VERIFY
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;
`endif

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/reg_bus_cmd_fifo.sv
// Command queue for reg_bus_master: DEPTH-entry FIFO (power of 2).
// Ports: CLK, RST (sync, active-high), i_push/i_data, i_pop/o_data,
// o_full, o_empty. Push is ignored when full, pop when empty.
module reg_bus_cmd_fifo
    import reg_bus_pkg::*;
#(
    parameter int W     = $bits(cmd_t),
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rp];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// Queued register bus master: commands are buffered, issued one at a
// time as single-cycle WRITE/READ strobes, reads return a one-cycle
// response RD_LAT+1 cycles after READ.
// Ports: CLK, RST (sync, active-high); CMD_* command in; RSP_* response
// out; WRITE/READ/ADDR/WRITE_DATA/READ_DATA register bus; BUSY.
// Optional macro REG_BUS_MASTER_RBV_EN: read-back verify after writes.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              WRITE,
    output logic              READ,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA,
    output logic              BUSY
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_w_t;

    localparam int CMD_W = $bits(cmd_w_t);
    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    cmd_w_t            w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_we;
    logic              r_write;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_valid;
`ifdef REG_BUS_MASTER_RBV_EN
    logic              r_chk;
    logic              r_rsp_err;
`endif

    reg_bus_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (CMD_VALID),
        .i_data  ({CMD_WE, CMD_ADDR, CMD_WDATA}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign CMD_READY  = !w_full && !RST;
    assign BUSY       = !w_empty || (r_state != S_IDLE);
    assign WRITE      = r_write;
    assign READ       = r_read;
    assign ADDR       = r_addr;
    assign WRITE_DATA = r_wdata;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_RDATA  = r_rdata;
`ifdef REG_BUS_MASTER_RBV_EN
    assign RSP_ERR    = r_rsp_err;
`else
    assign RSP_ERR    = 1'b0;
`endif

    // Strobes and RSP_VALID default low every cycle so each is a
    // single-cycle pulse; ADDR/WRITE_DATA/RSP_RDATA hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
`ifdef REG_BUS_MASTER_RBV_EN
            r_chk       <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_we    <= w_head.we;
                        r_write <= w_head.we;
                        r_read  <= !w_head.we;
                        r_addr  <= w_head.addr;
                        if (w_head.we) begin
                            r_wdata <= w_head.wdata;
                        end
`ifdef REG_BUS_MASTER_RBV_EN
                        r_chk   <= 1'b0;
`endif
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                    if (!r_we) begin
                        r_state <= S_WAIT;
                    end else begin
`ifdef REG_BUS_MASTER_RBV_EN
                        r_state <= S_VERIFY;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_rdata     <= READ_DATA;
                        r_rsp_valid <= 1'b1;
`ifdef REG_BUS_MASTER_RBV_EN
                        r_rsp_err   <= r_chk && (READ_DATA != r_wdata);
`endif
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef REG_BUS_MASTER_RBV_EN
                // Gap cycle after the write, then re-issue as a read
                // of the same address; r_wdata still holds the
                // value to compare against.
                S_VERIFY: begin
                    r_read  <= 1'b1;
                    r_we    <= 1'b0;
                    r_chk   <= 1'b1;
                    r_state <= S_ISSUE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: scoreboard of expected bus
// cycles and responses, latency checks for RD_LAT=4 and RD_LAT=1.
module tb_reg_bus_master;

    localparam int AW  = 3;
    localparam int DW  = 2;
    localparam int LAT = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          cmd_valid = 1'b0;
    logic          cmd_we    = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;

    logic          l_valid = 1'b0;
    logic          l_we    = 1'b0;
    logic [AW-1:0] l_addr  = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          l_ready;
    logic          l_rsp_valid;
    logic [DW-1:0] l_rsp_rdata;
    logic          l_rsp_err;
    logic          l_wr;
    logic          l_rd;
    logic [AW-1:0] l_addr_o;
    logic [DW-1:0] l_wdata_o;
    logic [DW-1:0] l_rd_data;
    logic          l_busy;

    reg_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_WE(cmd_we), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .WRITE(wr), .READ(rd), .ADDR(addr), .WRITE_DATA(wr_data),
        .READ_DATA(rd_data), .BUSY(busy)
    );

    reg_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut_l1 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(l_valid), .CMD_READY(l_ready),
        .CMD_WE(l_we), .CMD_ADDR(l_addr), .CMD_WDATA(l_wdata),
        .RSP_VALID(l_rsp_valid), .RSP_RDATA(l_rsp_rdata), .RSP_ERR(l_rsp_err),
        .WRITE(l_wr), .READ(l_rd), .ADDR(l_addr_o), .WRITE_DATA(l_wdata_o),
        .READ_DATA(l_rd_data), .BUSY(l_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cyc = -100;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Responder for the RD_LAT=4 instance: data is valid only in the
    // cycle exactly RD_LAT after READ, zero otherwise.
    logic [DW-1:0] mem [8] = '{default: '0};
    logic [LAT-1:0] rd_hist = '0;
    logic [AW-1:0] a_hist [LAT] = '{default: '0};
    logic corrupt = 1'b0;

    always @(posedge CLK) begin
        if (wr) mem[addr] <= wr_data;
        rd_hist <= {rd_hist[LAT-2:0], rd};
        a_hist[0] <= addr;
        for (int i = 1; i < LAT; i++) a_hist[i] <= a_hist[i-1];
    end

    assign rd_data = !rd_hist[LAT-1] ? 2'b00 :
                     corrupt ? 2'b01 : mem[a_hist[LAT-1]];

    logic l_hist = 1'b0;
    always @(posedge CLK) l_hist <= l_rd;
    assign l_rd_data = l_hist ? 2'b11 : 2'b00;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } bus_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    bus_t bus_q [$];
    rsp_t rsp_q [$];
    logic [DW-1:0] shadow [8] = '{default: '0};

    always @(negedge CLK) begin : mon
        bus_t b;
        rsp_t r;
        cyc++;
        if (!RST) begin
            if (wr || rd) begin
                chk("strobe_excl", 32'(wr & rd), 32'd0);
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'({wr, rd}), 32'd0);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_kind", 32'(wr), 32'(b.we));
                    chk("bus_addr", 32'(addr), 32'(b.a));
                    if (b.we) chk("bus_wdata", 32'(wr_data), 32'(b.d));
                end
                if (rd) rd_cyc = cyc;
            end
            if (rsp_valid) begin
                chk("rsp_latency", 32'(cyc - rd_cyc), 32'(LAT + 1));
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.d));
                    chk("rsp_err", 32'(rsp_err), 32'(r.e));
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int n = 0;
        logic [DW-1:0] v;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        step();
        bus_q.push_back(bus_t'{we, a, d});
        if (we) begin
            shadow[a] = d;
`ifdef REG_BUS_MASTER_RBV_EN
            v = corrupt ? 2'b01 : d;
            bus_q.push_back(bus_t'{1'b0, a, d});
            rsp_q.push_back(rsp_t'{v, v != d});
`endif
        end else begin
            v = shadow[a];
            rsp_q.push_back(rsp_t'{v, 1'b0});
        end
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        while ((busy || bus_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
        repeat (3) step();
    endtask

    initial begin : main
        int n;
        int m;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("ready_in_rst", 32'(cmd_ready), 32'd0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outs", 32'({rsp_valid, rsp_err, wr, rd, busy}), 32'd0);
        chk("rst_buses", 32'({rsp_rdata, addr, wr_data}), 32'd0);
        step();

        send(1'b1, 3'd0, 2'b10);
        drain();
        chk("addr_hold", 32'(addr), 32'd0);
        chk("wdata_hold", 32'(wr_data), 32'(2'b10));

        send(1'b1, 3'd0, 2'b11);
        send(1'b0, 3'd0, 2'b00);
        send(1'b1, 3'd5, 2'b01);
        send(1'b0, 3'd5, 2'b00);
        drain();
        chk("rdata_hold", 32'(rsp_rdata), 32'(2'b01));

        send(1'b0, 3'd0, 2'b00);
        send(1'b1, 3'd1, 2'b01);
        send(1'b0, 3'd1, 2'b00);
        send(1'b1, 3'd2, 2'b11);
        send(1'b0, 3'd2, 2'b00);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        send(1'b1, 3'd7, 2'b10);
        send(1'b0, 3'd7, 2'b00);
        drain();
        chk("rdata_after_burst", 32'(rsp_rdata), 32'(2'b10));

        send(1'b0, 3'd0, 2'b00);
        cmd_valid = 1'b0;
        n = 0;
        while (!rd && n < 50) begin
            step();
            n++;
        end
        chk("wait_read", 32'(rd), 32'd1);
        step();
        RST = 1'b1;
        rsp_q.delete();
        bus_q.delete();
        @(negedge CLK);
        chk("ready_in_rst2", 32'(cmd_ready), 32'd0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst2_outs", 32'({rsp_valid, rsp_err, wr, rd, busy}), 32'd0);
        chk("rst2_buses", 32'({rsp_rdata, addr, wr_data}), 32'd0);
        repeat (10) step();

`ifdef REG_BUS_MASTER_RBV_EN
        corrupt = 1'b1;
        send(1'b1, 3'd3, 2'b10);
        drain();
        corrupt = 1'b0;
        chk("rbv_rdata", 32'(rsp_rdata), 32'(2'b01));
`else
        send(1'b1, 3'd3, 2'b10);
        drain();
        chk("err_tied", 32'(rsp_err), 32'd0);
`endif

        l_valid = 1'b1;
        l_we    = 1'b0;
        l_addr  = 3'd5;
        step();
        l_valid = 1'b0;
        n = 0;
        while (!l_rd && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("l1_read_seen", 32'(l_rd), 32'd1);
        chk("l1_addr", 32'(l_addr_o), 32'd5);
        m = 0;
        do begin
            @(negedge CLK);
            m++;
        end while (!l_rsp_valid && m < 20);
        chk("l1_latency", 32'(m), 32'd2);
        chk("l1_rdata", 32'(l_rsp_rdata), 32'(2'b11));
        chk("l1_err", 32'(l_rsp_err), 32'd0);

        step();
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 Parameter ADDR_W, default 3, register address width.
REQ-002 Parameter DATA_W, default 2, register data width.
REQ-003 Parameter RD_LAT, default 1, cycles from READ asserted to READ_DATA valid (1..4).
REQ-004 Parameter FIFO_DEPTH, default 4, command queue entries (power of 2).
REQ-005 CLK  in  1  clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 CMD_VALID  in  1  command offered.
REQ-008 CMD_READY  out  1  command queue can accept.
REQ-009 CMD_WE  in  1  1 = write, 0 = read.
REQ-010 CMD_ADDR  in  ADDR_W  target address.
REQ-011 CMD_WDATA  in  DATA_W  write data.
REQ-012 RSP_VALID  out  1  one-cycle pulse, response present.
REQ-013 RSP_RDATA  out  DATA_W  read data captured.
REQ-014 RSP_ERR  out  1  readback mismatch flag (RBV only).
REQ-015 WRITE  out  1  register bus write strobe.
REQ-016 READ  out  1  register bus read strobe.
REQ-017 ADDR  out  ADDR_W  register bus address.
REQ-018 WRITE_DATA  out  DATA_W  register bus write data.
REQ-019 READ_DATA  in  DATA_W  register bus read data.
REQ-020 BUSY  out  1  queue non-empty or FSM not IDLE.

Function
REQ-021 Command accepted on the cycle CMD_VALID && CMD_READY; CMD_READY = !full, independent of CMD_VALID.
REQ-022 Full queue: CMD_READY low; a pop in the same cycle does not raise CMD_READY until the next cycle.
REQ-023 FSM states IDLE, ISSUE, WAIT, VERIFY; IDLE->ISSUE when queue non-empty, popping head.
REQ-024 ISSUE: exactly one cycle of WRITE=1 (write) or READ=1 (read) with ADDR/WRITE_DATA from the head entry; all bus outputs registered.
REQ-025 Write: ISSUE->IDLE; no response generated (RBV off).
REQ-026 Read: ISSUE->WAIT; WAIT counts RD_LAT cycles, samples READ_DATA on the last, drives RSP_VALID=1 with RSP_RDATA for one cycle, ->IDLE.
REQ-027 WRITE and READ never asserted together; minimum one idle bus cycle between commands.
REQ-028 RSP has no backpressure; RSP_RDATA holds last value between pulses.
REQ-029 ADDR/WRITE_DATA hold last driven value when strobes low.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; order strictly preserved.

Reset
REQ-031 RST clears queue, FSM->IDLE, WAIT counter 0; in-flight command dropped, no RSP issued.
REQ-032 Reset values: CMD_READY=0 during RST, 1 the cycle after; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, WRITE=0, READ=0, ADDR=0, WRITE_DATA=0, BUSY=0.

Configuration
REQ-033 Macro REG_BUS_MASTER_RBV_EN: when defined, each write is followed by VERIFY: read of same address, RD_LAT wait, compare; RSP_VALID pulses with RSP_RDATA=read value, RSP_ERR=1 on mismatch.
REQ-034 Without REG_BUS_MASTER_RBV_EN: VERIFY state absent, RSP_ERR tied 0, writes produce no response.

Structure
REQ-035 Package reg_bus_pkg holds state enum type, default ADDR_W/DATA_W constants and command struct (we, addr, wdata).
REQ-036 Sub-module reg_bus_cmd_fifo implements the command queue; FSM and response logic in reg_bus_master.

Verification
REQ-037 Write addr 0 data 2'b10 -> WRITE=1 one cycle with ADDR=0, WRITE_DATA=2'b10; no RSP_VALID.
REQ-038 Write 2'b11 to 0 then read 0 with responder model -> READ one cycle, RSP_VALID RD_LAT+1 cycles after READ, RSP_RDATA=2'b11.
REQ-039 Push 5 commands back-to-back with bus stalled by earlier read -> CMD_READY low after 4th accepted, all 5 issued in order.
REQ-040 Assert RST during WAIT -> no RSP_VALID, BUSY=0, all bus outputs 0 next cycle.
REQ-041 RBV enabled, responder returns 2'b01 after write of 2'b10 -> RSP_VALID=1, RSP_ERR=1, RSP_RDATA=2'b01.
REQ-042 Sweep RD_LAT 1 and 4 -> read response latency tracks parameter exactly.
